seq_shifter: RTL and testbench

//   Parametrised multi-cycle shifter; successor to the fixed combinational shift-left-by-2 jump-address stage.

---
 rtl/seq_shifter.sv | 104 ++++++++++
 tb/tb_seq_shifter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROL shifter, STEP bits per cycle,
// valid/ready handshake on request and result sides.
module seq_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         mode,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   din,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   dout,
    output logic               busy
);

    // one extra bit so STEP == WIDTH still fits in the count domain
    localparam int CW = SHAMT_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] data, data_nxt, shifted;
    logic [1:0]       op, op_nxt;
    logic [CW-1:0]    cnt, cnt_nxt, s, rs;
    logic             load;

    always_comb begin
        s  = (cnt < CW'(STEP)) ? cnt : CW'(STEP);
        rs = CW'(WIDTH) - s;
        unique case (op)
            2'b00: shifted = data << s;
            2'b01: shifted = data >> s;
            2'b10: shifted = $unsigned($signed(data) >>> s);
            2'b11: shifted = (data << s) | (data >> rs);
        endcase
    end

    always_comb begin
        state_nxt = state;
        data_nxt  = data;
        cnt_nxt   = cnt;
        op_nxt    = op;
        load      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    data_nxt = din;
                    op_nxt   = mode;
                    cnt_nxt  = {1'b0, shamt};
                    if (shamt == '0) begin
                        state_nxt = DONE;
                        load      = 1'b1;
                    end else begin
                        state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                data_nxt = shifted;
                cnt_nxt  = cnt - s;
                if (cnt_nxt == '0) begin
                    state_nxt = DONE;
                    load      = 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            data  <= '0;
            op    <= '0;
            cnt   <= '0;
            dout  <= '0;
        end else begin
            state <= state_nxt;
            data  <= data_nxt;
            op    <= op_nxt;
            cnt   <= cnt_nxt;
            if (load) dout <= data_nxt;
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: STEP=1 and STEP=4 instances side by side,
// checked against a whole-shift reference model every cycle.
module tb_seq_shifter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [1:0]  mode;
    logic [4:0]  shamt;
    logic [31:0] din;
    logic        out_ready;
    logic        rdy [2];
    logic        ov  [2];
    logic        bz  [2];
    logic [31:0] dq  [2];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_shifter #(.WIDTH(32), .STEP(1)) u_s1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
        .mode(mode), .shamt(shamt), .din(din), .out_valid(ov[0]),
        .out_ready(out_ready), .dout(dq[0]), .busy(bz[0])
    );

    seq_shifter #(.WIDTH(32), .STEP(4)) u_s4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
        .mode(mode), .shamt(shamt), .din(din), .out_valid(ov[1]),
        .out_ready(out_ready), .dout(dq[1]), .busy(bz[1])
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // whole-operand shift done in one go on a 64-bit scratch value
    function automatic logic [31:0] ref_shift(logic [1:0] m, logic [4:0] sh,
                                              logic [31:0] d);
        logic [63:0] t;
        case (m)
            2'd0:    t = {32'h0, d} << sh;
            2'd1:    t = {32'h0, d} >> sh;
            2'd2:    t = {{32{d[31]}}, d} >> sh;
            default: t = {d, d} << sh;
        endcase
        return (m == 2'd3) ? t[63:32] : t[31:0];
    endfunction

    // model: 0 idle, 1 busy counting down edges, 2 result held
    int          ph   [2];
    int          rem  [2];
    logic [31:0] expr [2];
    logic [31:0] expd [2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                ph[i]   <= 0;
                rem[i]  <= 0;
                expd[i] <= '0;
                expr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (ph[i])
                    0: if (in_valid) begin
                        expr[i] <= ref_shift(mode, shamt, din);
                        rem[i]  <= (int'(shamt) + (i ? 4 : 1) - 1) / (i ? 4 : 1);
                        if (shamt == 5'd0) begin
                            ph[i]   <= 2;
                            expd[i] <= ref_shift(mode, shamt, din);
                        end else begin
                            ph[i] <= 1;
                        end
                    end
                    1: begin
                        rem[i] <= rem[i] - 1;
                        if (rem[i] == 1) begin
                            ph[i]   <= 2;
                            expd[i] <= expr[i];
                        end
                    end
                    default: if (out_ready) ph[i] <= 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("in_ready[%0d]", i), 32'(rdy[i]), 32'(ph[i] == 0));
            chk($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(ph[i] == 2));
            chk($sformatf("busy[%0d]", i), 32'(bz[i]), 32'(ph[i] != 0));
            chk($sformatf("dout[%0d]", i), dq[i], expd[i]);
        end
    end

    task automatic run(string nm, logic [1:0] m, logic [4:0] sh,
                       logic [31:0] d, logic [31:0] exp, int l1, int l4);
        int          lat  [2];
        logic [31:0] got  [2];
        bit          seen [2];
        int          k;
        seen = '{0, 0};
        lat  = '{0, 0};
        got  = '{32'h0, 32'h0};
        @(posedge clk); #1;
        in_valid = 1'b1;
        mode     = m;
        shamt    = sh;
        din      = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mode     = 2'($urandom);
        shamt    = 5'($urandom);
        din      = $urandom;
        k = 1;
        while (!(seen[0] && seen[1]) && k <= 100) begin
            for (int i = 0; i < 2; i++) begin
                if (!seen[i] && ov[i]) begin
                    seen[i] = 1'b1;
                    lat[i]  = k;
                    got[i]  = dq[i];
                end
            end
            if (!(seen[0] && seen[1])) begin
                @(posedge clk); #1;
                k++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s timeout s%0d", nm, i ? 4 : 1), 32'(seen[i]), 32'd1);
            chk($sformatf("%s result s%0d", nm, i ? 4 : 1), got[i], exp);
            chk($sformatf("%s latency s%0d", nm, i ? 4 : 1), 32'(lat[i]),
                32'(i ? l4 : l1));
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        mode      = 2'd0;
        shamt     = 5'd0;
        din       = 32'h0;
        out_ready = 1'b1;
        #3;
        for (int i = 0; i < 2; i++) begin
            chk("reset in_ready", 32'(rdy[i]), 32'd1);
            chk("reset out_valid", 32'(ov[i]), 32'd0);
            chk("reset busy", 32'(bz[i]), 32'd0);
            chk("reset dout", dq[i], 32'h0);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        run("T1 sll",    2'd0, 5'd2,  32'h03FF_FFFF, 32'h0FFF_FFFC, 3, 2);
        run("T2 sra",    2'd2, 5'd4,  32'h8000_0010, 32'hF800_0001, 5, 2);
        run("T2 srl",    2'd1, 5'd4,  32'h8000_0010, 32'h0800_0001, 5, 2);
        run("T3 rol",    2'd3, 5'd1,  32'h8000_0001, 32'h0000_0003, 2, 2);
        run("T3 zero",   2'd1, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 1);
        run("T4 sll31",  2'd0, 5'd31, 32'h0000_0001, 32'h8000_0000, 32, 9);
        run("T4 sll6",   2'd0, 5'd6,  32'h0000_0001, 32'h0000_0040, 7, 3);
        run("rol8",      2'd3, 5'd8,  32'h1234_5678, 32'h3456_7812, 9, 3);
        run("sra31 neg", 2'd2, 5'd31, 32'hF000_0000, 32'hFFFF_FFFF, 32, 9);
        run("sra31 pos", 2'd2, 5'd31, 32'h7000_0000, 32'h0000_0000, 32, 9);
        run("srl31",     2'd1, 5'd31, 32'h8000_0000, 32'h0000_0001, 32, 9);
        run("sra5",      2'd2, 5'd5,  32'h8000_0000, 32'hFC00_0000, 6, 3);

        // T5: result held under backpressure, in_valid ignored
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        mode      = 2'd0;
        shamt     = 5'd1;
        din       = 32'hA;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            in_valid = ~in_valid;
            din      = $urandom;
            shamt    = 5'd3;
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                chk("T5 hold in_ready", 32'(rdy[i]), 32'd0);
                chk("T5 hold out_valid", 32'(ov[i]), 32'd1);
                chk("T5 hold dout", dq[i], 32'h14);
            end
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("T5 release in_ready", 32'(rdy[i]), 32'd1);
            chk("T5 release out_valid", 32'(ov[i]), 32'd0);
            chk("T5 release dout", dq[i], 32'h14);
        end

        // T6: async reset in the middle of a 20-bit shift
        @(posedge clk); #1;
        in_valid = 1'b1;
        mode     = 2'd0;
        shamt    = 5'd20;
        din      = 32'h1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++)
            chk("T6 busy before reset", 32'(bz[i]), 32'd1);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("T6 async out_valid", 32'(ov[i]), 32'd0);
            chk("T6 async dout", dq[i], 32'h0);
            chk("T6 async busy", 32'(bz[i]), 32'd0);
            chk("T6 async in_ready", 32'(rdy[i]), 32'd1);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        run("T6 after", 2'd3, 5'd20, 32'h0000_0F01, 32'hF010_0000, 21, 6);

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
